fv_replay_sched: RTL and testbench

- Sequences the replay iterations of one GNN task over the two Big_FV ping/pong wrappers.
- Issues packet requests to the packet fetch front-end and counts completed packets.
- Drains outstanding feature-value writes, then swaps the ping/pong roles.
- Drives Current_replay_Iter and task_complete for the top level.

---
 rtl/fv_replay_sched.sv | 153 +++++++++++++++
 tb/tb_fv_replay_sched.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fv_replay_sched.sv
// Replay-iteration sequencer for one GNN task: issues packets, counts completions,
// drains pong-wrapper writes, then swaps ping/pong roles until NUM_ITER iterations finish.
module fv_replay_sched #(
  parameter int unsigned NUM_ITER  = 4,
  parameter int unsigned ITER_W    = 2,
  parameter int unsigned NUM_BANK  = 4,
  parameter int unsigned PKT_CNT_W = 16,
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PKT_CNT_W-1:0] num_packets,
  output logic                 pkt_req,
  input  logic                 pkt_ack,
  input  logic                 pkt_done,
  input  logic [NUM_BANK-1:0]  wr_busy,
  output logic                 ping_sel,
  output logic [ITER_W-1:0]    Current_replay_Iter,
  output logic                 iter_done,
  output logic                 task_complete,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_DONE, S_DRAIN, S_SWAP, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [PKT_CNT_W-1:0] num_q, num_d;
  logic [PKT_CNT_W-1:0] issued_q, issued_d;
  logic [PKT_CNT_W-1:0] done_q, done_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [ITER_W-1:0]    iter_q, iter_d;
  logic                 ping_q, ping_d;
  logic                 iter_done_q, iter_done_d;
  logic                 tc_q, tc_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 done_valid;
  logic                 done_bad;

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    issued_d    = issued_q;
    done_d      = done_q;
    drain_d     = drain_q;
    iter_d      = iter_q;
    ping_d      = ping_q;
    iter_done_d = 1'b0;
    tc_d        = (state_q == S_DONE);
    err_d       = err_q;

    pkt_req    = (state_q == S_ISSUE) && (issued_q < num_q);
    // A completion only counts while packets are in flight in this iteration.
    done_valid = pkt_done && ((state_q == S_ISSUE) || (state_q == S_WAIT_DONE)) &&
                 (done_q != issued_q);
    done_bad   = pkt_done && !done_valid;

    if (done_valid) done_d = done_q + PKT_CNT_W'(1);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          num_d    = num_packets;
          issued_d = '0;
          done_d   = '0;
          drain_d  = '0;
          err_d    = 1'b0;
          tc_d     = 1'b0;
          iter_d   = '0;
          ping_d   = 1'b0;
          state_d  = (num_packets == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (pkt_req && pkt_ack) begin
          issued_d = issued_q + PKT_CNT_W'(1);
          if (issued_d == num_q) state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (done_d == num_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (|wr_busy) begin
          drain_d = '0;
        end else if (drain_q == DRAIN_W'(DRAIN_CYC - 1)) begin
          state_d = S_SWAP;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      S_SWAP: begin
        iter_done_d = 1'b1;
        ping_d      = ~ping_q;
        issued_d    = '0;
        done_d      = '0;
        drain_d     = '0;
        if (iter_q == ITER_W'(NUM_ITER - 1)) begin
          state_d = S_DONE;
        end else begin
          iter_d  = iter_q + ITER_W'(1);
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    err_d  = err_d | done_bad;
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      issued_q    <= '0;
      done_q      <= '0;
      drain_q     <= '0;
      iter_q      <= '0;
      ping_q      <= 1'b0;
      iter_done_q <= 1'b0;
      tc_q        <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      issued_q    <= issued_d;
      done_q      <= done_d;
      drain_q     <= drain_d;
      iter_q      <= iter_d;
      ping_q      <= ping_d;
      iter_done_q <= iter_done_d;
      tc_q        <= tc_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign ping_sel            = ping_q;
  assign Current_replay_Iter = iter_q;
  assign iter_done           = iter_done_q;
  assign task_complete       = tc_q;
  assign busy                = busy_q;
  assign err                 = err_q;

endmodule

// File: tb/tb_fv_replay_sched.sv
// Directed bench for fv_replay_sched: full task, ack stall, drain gating,
// zero-packet task, mid-task reset and protocol error handling.
module tb_fv_replay_sched;

  logic        clk = 1'b0;
  logic        reset, start, pkt_req, pkt_ack, pkt_done;
  logic [15:0] num_packets;
  logic [3:0]  wr_busy;
  logic        ping_sel, iter_done, task_complete, busy, err;
  logic [1:0]  Current_replay_Iter;

  int checks = 0;
  int errors = 0;

  int         cyc, hs_total, hs_iter, bad_iter_hs, iter_pulses, ping_toggles;
  int         dn_count, last_iter_done_cyc;
  bit         req_seen;
  logic [1:0] pipe;
  logic       prev_ping;
  logic [1:0] iter_log [4];

  fv_replay_sched #(
    .NUM_ITER(4), .ITER_W(2), .NUM_BANK(4), .PKT_CNT_W(16), .DRAIN_CYC(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_packets(num_packets),
    .pkt_req(pkt_req), .pkt_ack(pkt_ack), .pkt_done(pkt_done), .wr_busy(wr_busy),
    .ping_sel(ping_sel), .Current_replay_Iter(Current_replay_Iter),
    .iter_done(iter_done), .task_complete(task_complete), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // One clock: note handshakes, advance, then drive pkt_done two cycles after each ack.
  task automatic tick();
    logic hs;
    hs = pkt_req && pkt_ack;
    if (hs) begin hs_total++; hs_iter++; end
    if (pkt_req === 1'b1) req_seen = 1;
    if (pkt_done) dn_count++;
    @(posedge clk); #1;
    cyc++;
    if (reset) pipe = '0; else pipe = {pipe[0], hs};
    pkt_done = pipe[1];
    if (iter_done) begin
      if (iter_pulses < 4) iter_log[iter_pulses] = Current_replay_Iter;
      iter_pulses++;
      last_iter_done_cyc = cyc;
      if (hs_iter != 3) bad_iter_hs++;
      hs_iter = 0;
    end
    if (ping_sel !== prev_ping) ping_toggles++;
    prev_ping = ping_sel;
  endtask

  task automatic clear_obs();
    hs_total = 0; hs_iter = 0; bad_iter_hs = 0; iter_pulses = 0; ping_toggles = 0;
    dn_count = 0; last_iter_done_cyc = 0; req_seen = 0;
    for (int i = 0; i < 4; i++) iter_log[i] = '0;
  endtask

  task automatic do_reset();
    reset = 1; start = 0; pkt_ack = 0; wr_busy = '0; num_packets = '0;
    tick(); tick();
    reset = 0; pkt_done = 0;
    prev_ping = ping_sel;
  endtask

  task automatic do_start(input logic [15:0] n);
    num_packets = n; start = 1;
    tick();
    start = 0;
  endtask

  task automatic run_until_done(input int budget, output bit ok);
    int n = 0;
    while (!task_complete && n < budget) begin tick(); n++; end
    ok = task_complete;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    int n = 0;
    while (dn_count < 3 && n < budget) begin tick(); n++; end
    ok = (dn_count >= 3);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ping_sel !== 1'b0) begin errors++; $display("FAIL reset_ping got %0b expected 0", ping_sel); end
    checks++; if (Current_replay_Iter !== 2'd0) begin errors++; $display("FAIL reset_iter got %0d expected 0", Current_replay_Iter); end
    checks++; if (iter_done !== 1'b0) begin errors++; $display("FAIL reset_iter_done got %0b expected 0", iter_done); end
    checks++; if (task_complete !== 1'b0) begin errors++; $display("FAIL reset_tc got %0b expected 0", task_complete); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b expected 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b expected 0", err); end
    checks++; if (pkt_req !== 1'b0) begin errors++; $display("FAIL reset_pkt_req got %0b expected 0", pkt_req); end
  endtask

  task automatic test_full_task();
    bit ok;
    logic [1:0] exp_iter [4];
    exp_iter[0] = 2'd1; exp_iter[1] = 2'd2; exp_iter[2] = 2'd3; exp_iter[3] = 2'd3;
    do_reset(); clear_obs();
    pkt_ack = 1; wr_busy = '0;
    do_start(16'd3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy got %0b expected 1", busy); end
    run_until_done(400, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL full_timeout got %0b expected 1", ok); end
    checks++; if (hs_total != 12) begin errors++; $display("FAIL full_handshakes got %0d expected 12", hs_total); end
    checks++; if (bad_iter_hs != 0) begin errors++; $display("FAIL full_hs_per_iter got %0d bad expected 0", bad_iter_hs); end
    checks++; if (iter_pulses != 4) begin errors++; $display("FAIL full_iter_done got %0d expected 4", iter_pulses); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (iter_log[i] !== exp_iter[i]) begin errors++; $display("FAIL full_iter_seq[%0d] got %0d expected %0d", i, iter_log[i], exp_iter[i]); end
    end
    checks++; if (ping_toggles != 4) begin errors++; $display("FAIL full_ping_toggles got %0d expected 4", ping_toggles); end
    checks++; if (ping_sel !== 1'b0) begin errors++; $display("FAIL full_ping_final got %0b expected 0", ping_sel); end
    checks++; if (cyc - last_iter_done_cyc != 1) begin errors++; $display("FAIL full_tc_latency got %0d expected 1", cyc - last_iter_done_cyc); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL full_err got %0b expected 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_done got %0b expected 0", busy); end
  endtask

  task automatic test_ack_stall();
    bit ok;
    int drops = 0;
    int h0;
    do_reset(); clear_obs();
    pkt_ack = 1; wr_busy = '0;
    do_start(16'd3);
    tick();
    pkt_ack = 0; h0 = hs_total;
    repeat (5) begin tick(); if (pkt_req !== 1'b1) drops++; end
    checks++; if (drops != 0) begin errors++; $display("FAIL stall_req_drop got %0d expected 0", drops); end
    checks++; if (hs_total != 1 || h0 != 1) begin errors++; $display("FAIL stall_issued got %0d expected 1", hs_total); end
    pkt_ack = 1;
    tick(); tick();
    checks++; if (hs_total != 3) begin errors++; $display("FAIL stall_resume got %0d expected 3", hs_total); end
    checks++; if (pkt_req !== 1'b0) begin errors++; $display("FAIL stall_req_after got %0b expected 0", pkt_req); end
    run_until_done(400, ok);
    checks++; if (ok !== 1'b1 || iter_pulses != 4) begin errors++; $display("FAIL stall_complete got %0d expected 4", iter_pulses); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL stall_err got %0b expected 0", err); end
  endtask

  task automatic test_drain();
    bit ok;
    int early = 0;
    do_reset(); clear_obs();
    pkt_ack = 1; wr_busy = 4'b0010;
    do_start(16'd3);
    wait_drain(50, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL drain_wait got %0b expected 1", ok); end
    repeat (10) begin tick(); if (iter_done) early++; end
    wr_busy = 4'b0000; tick(); if (iter_done) early++;
    wr_busy = 4'b0010; tick(); if (iter_done) early++;
    wr_busy = 4'b0000; tick();
    checks++; if (iter_done !== 1'b0 || early != 0) begin errors++; $display("FAIL drain_early got %0d expected 0", early + iter_done); end
    tick();
    checks++; if (iter_done !== 1'b0) begin errors++; $display("FAIL drain_swap_cycle got %0b expected 0", iter_done); end
    tick();
    checks++; if (iter_done !== 1'b1) begin errors++; $display("FAIL drain_iter_done got %0b expected 1", iter_done); end
    checks++; if (Current_replay_Iter !== 2'd1) begin errors++; $display("FAIL drain_iter got %0d expected 1", Current_replay_Iter); end
    checks++; if (ping_sel !== 1'b1) begin errors++; $display("FAIL drain_ping got %0b expected 1", ping_sel); end
  endtask

  task automatic test_zero_packets();
    do_reset(); clear_obs();
    pkt_ack = 1;
    do_start(16'd0);
    checks++; if (task_complete !== 1'b0) begin errors++; $display("FAIL zero_tc_first got %0b expected 0", task_complete); end
    tick();
    checks++; if (task_complete !== 1'b1) begin errors++; $display("FAIL zero_tc_second got %0b expected 1", task_complete); end
    checks++; if (Current_replay_Iter !== 2'd0) begin errors++; $display("FAIL zero_iter got %0d expected 0", Current_replay_Iter); end
    repeat (4) tick();
    checks++; if (req_seen != 0) begin errors++; $display("FAIL zero_req got %0d expected 0", req_seen); end
    checks++; if (iter_pulses != 0) begin errors++; $display("FAIL zero_iter_done got %0d expected 0", iter_pulses); end
    checks++; if (task_complete !== 1'b1) begin errors++; $display("FAIL zero_tc_hold got %0b expected 1", task_complete); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n = 0;
    do_reset(); clear_obs();
    pkt_ack = 1; wr_busy = '0;
    do_start(16'd3);
    while (!(Current_replay_Iter == 2'd2 && pkt_req) && n < 200) begin tick(); n++; end
    while (pkt_req && n < 220) begin tick(); n++; end
    checks++; if (Current_replay_Iter !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL mid_reach got %0d expected 2", Current_replay_Iter); end
    reset = 1; tick(); reset = 0;
    checks++; if (Current_replay_Iter !== 2'd0) begin errors++; $display("FAIL mid_iter got %0d expected 0", Current_replay_Iter); end
    checks++; if (busy !== 1'b0 || pkt_req !== 1'b0) begin errors++; $display("FAIL mid_busy got %0b expected 0", busy | pkt_req); end
    checks++; if (ping_sel !== 1'b0 || iter_done !== 1'b0) begin errors++; $display("FAIL mid_ping got %0b expected 0", ping_sel | iter_done); end
    checks++; if (task_complete !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mid_tc_err got %0b expected 0", task_complete | err); end
    prev_ping = ping_sel;
    clear_obs();
    do_start(16'd3);
    run_until_done(400, ok);
    checks++; if (ok !== 1'b1 || iter_pulses != 4) begin errors++; $display("FAIL mid_rerun got %0d expected 4", iter_pulses); end
    checks++; if (hs_total != 12) begin errors++; $display("FAIL mid_rerun_hs got %0d expected 12", hs_total); end
    checks++; if (err !== 1'b0 || ping_sel !== 1'b0) begin errors++; $display("FAIL mid_rerun_state got %0b expected 0", err | ping_sel); end
  endtask

  task automatic test_err();
    bit ok;
    do_reset(); clear_obs();
    pkt_ack = 1; wr_busy = 4'b0010;
    do_start(16'd3);
    wait_drain(50, ok);
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_before got %0b expected 0", err); end
    pkt_done = 1; tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %0b expected 1", err); end
    wr_busy = '0;
    run_until_done(400, ok);
    checks++; if (ok !== 1'b1 || iter_pulses != 4) begin errors++; $display("FAIL err_complete got %0d expected 4", iter_pulses); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b expected 1", err); end
    do_start(16'd3);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %0b expected 0", err); end
    checks++; if (task_complete !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL err_restart got %0b expected 1", busy & ~task_complete); end
  endtask

  initial begin
    reset = 1; start = 0; pkt_ack = 0; pkt_done = 0; wr_busy = '0; num_packets = '0;
    cyc = 0; pipe = '0; prev_ping = 1'b0;
    clear_obs();
    test_reset();
    test_full_task();
    test_ack_stall();
    test_drain();
    test_zero_packets();
    test_reset_mid();
    test_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
